// File: rtl/fu_issue_pkg.sv
// rtl/fu_issue_pkg.sv - op encodings, unit indices and queue entry type for the FU issue scheduler
package fu_issue_pkg;

    localparam int ENTRY_TAG_W = 4;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_MULT    = 2'b01,
        OP_MULADD  = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    localparam int U_ADD    = 0;
    localparam int U_MULT   = 1;
    localparam int U_MULADD = 2;
    localparam int N_UNITS  = 3;

    typedef enum logic {
        U_IDLE = 1'b0,
        U_BUSY = 1'b1
    } unit_state_t;

    typedef struct packed {
        op_t                    op;
        logic [ENTRY_TAG_W-1:0] tag;
        logic [31:0]            src1;
        logic [31:0]            src2;
        logic [31:0]            src3;
    } issue_entry_t;

endpackage

// File: rtl/fu_issue_fifo.sv
// rtl/fu_issue_fifo.sv - DEPTH-entry synchronous FIFO of decoded ops feeding the issue logic
module fu_issue_fifo
    import fu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  issue_entry_t push_data,
    input  logic         pop,
    output issue_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    issue_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// rtl/fu_issue_scheduler.sv - in-order issue of queued ADD/MULT/MULADD ops to idle functional units
module fu_issue_scheduler
    import fu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = ENTRY_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [31:0]      in_src3,
    output logic             add_issue,
    output logic [31:0]      add_src1,
    output logic [31:0]      add_src2,
    output logic [TAG_W-1:0] add_tag,
    output logic             mult_issue,
    output logic [31:0]      mult_src1,
    output logic [31:0]      mult_src2,
    output logic [TAG_W-1:0] mult_tag,
    output logic             muladd_issue,
    output logic [31:0]      muladd_src1,
    output logic [31:0]      muladd_src2,
    output logic [31:0]      muladd_src3,
    output logic [TAG_W-1:0] muladd_tag,
    input  logic             add_done,
    input  logic             mult_done,
    input  logic             muladd_done,
    output logic             illegal_op,
    output logic [TAG_W-1:0] illegal_tag,
    output logic             proto_err,
    output logic [2:0]       busy
);

    issue_entry_t         in_entry;
    issue_entry_t         head;
    logic                 full;
    logic                 empty;
    logic                 drop;
    logic [N_UNITS-1:0]   done_vec;
    logic [N_UNITS-1:0]   can_go;
    logic [N_UNITS-1:0]   fire;
    unit_state_t          state [N_UNITS];

    assign in_entry = '{op: op_t'(in_op), tag: ENTRY_TAG_W'(in_tag),
                        src1: in_src1, src2: in_src2, src3: in_src3};
    assign in_ready = !full;
    assign done_vec = {muladd_done, mult_done, add_done};
    assign busy     = {state[U_MULADD] == U_BUSY, state[U_MULT] == U_BUSY, state[U_ADD] == U_BUSY};

    fu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_entry),
        .pop       (drop || (fire != '0)),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A unit finishing this cycle can accept the next op in the same cycle.
    always_comb begin
        can_go = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            can_go[u] = (state[u] == U_IDLE) || done_vec[u];
        end
    end

    always_comb begin
        fire = '0;
        drop = 1'b0;
        if (!empty) begin
            case (head.op)
                OP_ADD:    fire[U_ADD]    = can_go[U_ADD];
                OP_MULT:   fire[U_MULT]   = can_go[U_MULT];
                OP_MULADD: fire[U_MULADD] = can_go[U_MULADD];
                default:   drop           = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < N_UNITS; u++) state[u] <= U_IDLE;
            add_issue    <= 1'b0;
            add_src1     <= '0;
            add_src2     <= '0;
            add_tag      <= '0;
            mult_issue   <= 1'b0;
            mult_src1    <= '0;
            mult_src2    <= '0;
            mult_tag     <= '0;
            muladd_issue <= 1'b0;
            muladd_src1  <= '0;
            muladd_src2  <= '0;
            muladd_src3  <= '0;
            muladd_tag   <= '0;
            illegal_op   <= 1'b0;
            illegal_tag  <= '0;
            proto_err    <= 1'b0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                case (state[u])
                    U_IDLE: begin
                        if (fire[u])          state[u]  <= U_BUSY;
                        else if (done_vec[u]) proto_err <= 1'b1;
                    end
                    U_BUSY: begin
                        if (done_vec[u] && !fire[u]) state[u] <= U_IDLE;
                    end
                    default: state[u] <= U_IDLE;
                endcase
            end

            add_issue    <= fire[U_ADD];
            mult_issue   <= fire[U_MULT];
            muladd_issue <= fire[U_MULADD];
            illegal_op   <= drop;

            if (drop) illegal_tag <= TAG_W'(head.tag);
            if (fire[U_ADD]) begin
                add_src1 <= head.src1;
                add_src2 <= head.src2;
                add_tag  <= TAG_W'(head.tag);
            end
            if (fire[U_MULT]) begin
                mult_src1 <= head.src1;
                mult_src2 <= head.src2;
                mult_tag  <= TAG_W'(head.tag);
            end
            if (fire[U_MULADD]) begin
                muladd_src1 <= head.src1;
                muladd_src2 <= head.src2;
                muladd_src3 <= head.src3;
                muladd_tag  <= TAG_W'(head.tag);
            end
        end
    end

endmodule
